// File: rtl/mux2_arbiter.sv
// Two-requester round-robin arbiter sharing one inverting 2:1 mux, with a
// single-entry registered output stage. Define MUX2_ARB_BURST_EN for burst locking.
module mux2_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             in1_ready,
  input  logic             in2_valid,
  input  logic [WIDTH-1:0] in2_data,
  input  logic             in2_last,
  output logic             in2_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             mux_sel
);

  // Handshake: a beat moves on a port in any cycle where its valid and ready
  // are both high at the rising edge; ready never depends on data.
  logic             load_en;
  logic             grant_valid;
  logic             grant_sel;
  logic             last_q;      // last-served requester: 0 = in1, 1 = in2
  logic             sel_q;
  logic             rr_sel;
  logic             xfer;
  logic [WIDTH-1:0] mux_out;

  assign load_en = ~out_valid | out_ready;
  assign rr_sel  = (in1_valid & in2_valid) ? ~last_q : in2_valid;

`ifdef MUX2_ARB_BURST_EN
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {OPEN, LOCKED} lock_t;

  lock_t         lock_q, lock_d;
  logic          owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          xfer_last;

  assign xfer_last = mux_sel ? in2_last : in1_last;

  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = sel_q;
    if (!rst) begin
      if (lock_q == LOCKED) begin
        grant_valid = owner_q ? in2_valid : in1_valid;
        grant_sel   = owner_q;
      end else begin
        grant_valid = in1_valid | in2_valid;
        grant_sel   = rr_sel;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q  <= OPEN;
      owner_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // A single-beat limit can never lock, so OPEN is kept when MAX_BURST is 1.
  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (xfer) begin
      if (lock_q == OPEN) begin
        if (!xfer_last && MAX_BURST > 1) begin
          lock_d  = LOCKED;
          owner_d = mux_sel;
          cnt_d   = CW'(1);
        end
      end else if (xfer_last || (cnt_q + CW'(1)) == CW'(MAX_BURST)) begin
        lock_d = OPEN;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end
`else
  logic unused_last;
  assign unused_last = in1_last ^ in2_last;

  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = sel_q;
    if (!rst) begin
      grant_valid = in1_valid | in2_valid;
      grant_sel   = rr_sel;
    end
  end
`endif

  assign mux_sel   = grant_valid ? grant_sel : sel_q;
  assign mux_out   = mux_sel ? ~in2_data : ~in1_data;
  assign in1_ready = load_en & grant_valid & ~mux_sel & in1_valid;
  assign in2_ready = load_en & grant_valid & mux_sel & in2_valid;
  assign xfer      = in1_ready | in2_ready;

  // Pointer reset to in2 so in1 wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      last_q    <= 1'b1;
      sel_q     <= 1'b0;
    end else begin
      sel_q <= mux_sel;
      if (xfer) begin
        out_data  <= ~mux_out;
        out_valid <= 1'b1;
        last_q    <= mux_sel;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed bench for mux2_arbiter: expected beats are queued when issued and
// a monitor pops and compares them as the output register presents them.
module tb_mux2_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in1_valid, in1_last, in1_ready;
  logic         in2_valid, in2_last, in2_ready;
  logic [W-1:0] in1_data, in2_data, out_data;
  logic         out_valid, out_ready, mux_sel;

  logic [W-1:0] exp_q[$];
  int           n_chk  = 0;
  int           n_fail = 0;

  mux2_arbiter #(.WIDTH(W), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
    .in2_valid(in2_valid), .in2_data(in2_data), .in2_last(in2_last), .in2_ready(in2_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .mux_sel(mux_sel)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: one vector per cycle, readies and select checked mid-cycle
  task automatic step(input logic v1, input logic [W-1:0] d1, input logic l1,
                      input logic v2, input logic [W-1:0] d2, input logic l2,
                      input logic ordy, input logic er1, input logic er2, input logic esel);
    @(posedge clk);
    #1;
    in1_valid = v1; in1_data = d1; in1_last = l1;
    in2_valid = v2; in2_data = d2; in2_last = l2;
    out_ready = ordy;
    @(negedge clk);
    chk("in1_ready", {31'd0, in1_ready}, {31'd0, er1});
    chk("in2_ready", {31'd0, in2_ready}, {31'd0, er2});
    chk("mux_sel", {31'd0, mux_sel}, {31'd0, esel});
    if (er1) exp_q.push_back(d1);
    else if (er2) exp_q.push_back(d2);
  endtask

  // monitor: front of queue must be on the output whenever it is valid
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL out_unexpected: got %0h expected none at %0t", out_data, $time);
        end else begin
          chk("out_data", {24'd0, out_data}, {24'd0, exp_q[0]});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [W-1:0] d;
    rst = 1'b1;
    in1_valid = 1'b1; in1_data = 8'h00; in1_last = 1'b1;
    in2_valid = 1'b1; in2_data = 8'h00; in2_last = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_in1_ready", {31'd0, in1_ready}, 32'd0);
    chk("rst_in2_ready", {31'd0, in2_ready}, 32'd0);
    chk("rst_mux_sel", {31'd0, mux_sel}, 32'd0);
    in1_valid = 1'b0; in2_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // single beat, idle hold, then in2 alone
    step(1, 8'hA5, 1, 0, 8'h00, 1, 1, 1, 0, 0);
    step(0, 8'h00, 1, 0, 8'h00, 1, 1, 0, 0, 0);
    step(0, 8'h00, 1, 1, 8'h5A, 1, 1, 0, 1, 1);
    // continuous contention alternates with no bubbles
    step(1, 8'h11, 1, 1, 8'h22, 1, 1, 1, 0, 0);
    step(1, 8'h11, 1, 1, 8'h22, 1, 1, 0, 1, 1);
    step(1, 8'h11, 1, 1, 8'h22, 1, 1, 1, 0, 0);
    step(1, 8'h11, 1, 1, 8'h22, 1, 1, 0, 1, 1);
    // backpressure stalls both, resume in the same cycle out_ready rises
    step(1, 8'h11, 1, 1, 8'h22, 1, 0, 0, 0, 0);
    step(1, 8'h11, 1, 1, 8'h22, 1, 0, 0, 0, 0);
    step(1, 8'h11, 1, 1, 8'h22, 1, 1, 1, 0, 0);
    step(0, 8'h00, 1, 1, 8'h33, 1, 1, 0, 1, 1);

    // asynchronous reset mid-cycle while the output holds a beat
    @(posedge clk);
    #1;
    in1_valid = 1'b0; in2_valid = 1'b0;
    #1;
    chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    chk("pre_rst_out_data", {24'd0, out_data}, 32'h33);
    #1;
    exp_q.delete();
    rst = 1'b1;
    in1_valid = 1'b1; in2_valid = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_out_data", {24'd0, out_data}, 32'd0);
    chk("mid_rst_in1_ready", {31'd0, in1_ready}, 32'd0);
    chk("mid_rst_in2_ready", {31'd0, in2_ready}, 32'd0);
    chk("mid_rst_mux_sel", {31'd0, mux_sel}, 32'd0);
    in1_valid = 1'b0; in2_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1, 8'h44, 1, 1, 8'h55, 1, 1, 1, 0, 0);
    step(1, 8'h44, 1, 1, 8'h55, 1, 1, 0, 1, 1);

`ifdef MUX2_ARB_BURST_EN
    // in1 streams with last=0: capped at four beats, then in2 gets a turn
    for (int i = 0; i < 4; i++) begin
      d = 8'h81 + W'(i);
      step(1, d, 0, 1, 8'h66, 1, 1, 1, 0, 0);
    end
    step(1, 8'h85, 0, 1, 8'h66, 1, 1, 0, 1, 1);
    // two-beat burst; owner gap holds the lock against in2
    step(1, 8'h91, 0, 1, 8'h66, 1, 1, 1, 0, 0);
    step(0, 8'h92, 1, 1, 8'h66, 1, 1, 0, 0, 0);
    step(1, 8'h92, 1, 1, 8'h66, 1, 1, 1, 0, 0);
    step(1, 8'h93, 0, 1, 8'h66, 1, 1, 0, 1, 1);
`else
    // last ignored: strict alternation
    for (int i = 0; i < 6; i++) begin
      d = 8'h81 + W'(i);
      step(1, d, 0, 1, 8'h66, 1, 1, 1, 0, 0);
      d = 8'h82 + W'(i);
      step(1, d, 0, 1, 8'h66, 1, 1, 0, 1, 1);
    end
`endif
    step(0, 8'h00, 1, 0, 8'h00, 1, 1, 0, 0, 1);
    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
